// File: rtl/apb_gpio_ctrl.sv
// apb_gpio_ctrl
//   APB3 slave GPIO controller: per-pin direction, atomic set/clear of the
//   output register, synchronised inputs, per-pin rising/falling edge
//   interrupts with sticky write-1-to-clear status, optional wait states.
//
//   Bus handshake: a transfer is one setup cycle (PSEL=1, PENABLE=0) followed
//   by access cycles (PSEL=1, PENABLE=1). PREADY is high for exactly one
//   access cycle, after WAIT_STATES cycles with PREADY=0. The transfer
//   completes on the PCLK edge ending that cycle, which is also when writes
//   commit. Dropping PSEL before PREADY aborts the transfer without a commit.
//
// Ports
//   PCLK, PRESETn      clock (rising edge) / asynchronous active-low reset
//   PSEL, PENABLE      APB select / access phase
//   PWRITE             1 = write, 0 = read
//   PADDR[ADDR_W]      byte address
//   PWDATA[32]         write data
//   PRDATA[32]         read data, non-zero only in the PREADY cycle of a good read
//   PREADY, PSLVERR    transfer done / error response (only with PREADY)
//   gpio_in[N_GPIO]    asynchronous pad inputs
//   gpio_out[N_GPIO]   output values (DATA_OUT)
//   gpio_oe[N_GPIO]    output enables (DIR, 1 = drive)
//   irq                level interrupt, OR of IRQ_STATUS
//   dbg_state[2]       transfer FSM state
module apb_gpio_ctrl #(
    parameter int N_GPIO      = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq,
    output logic [1:0]        dbg_state
);

    // IDLE covers both the idle and the setup bus phase; seeing a setup
    // phase in IDLE arms ACCESS for the following cycle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;

    localparam logic [2:0] REG_DATA_OUT = 3'd0;
    localparam logic [2:0] REG_DIR      = 3'd1;
    localparam logic [2:0] REG_DATA_IN  = 3'd2;
    localparam logic [2:0] REG_RISE_EN  = 3'd3;
    localparam logic [2:0] REG_FALL_EN  = 3'd4;
    localparam logic [2:0] REG_IRQ_STAT = 3'd5;
    localparam logic [2:0] REG_OUT_SET  = 3'd6;
    localparam logic [2:0] REG_OUT_CLR  = 3'd7;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              ready;
    logic [31:0]       addr_ext;
    logic [2:0]        reg_idx;
    logic              addr_err;
    logic              wr_en;
    logic [N_GPIO-1:0] wdata_n;
    logic [31:0]       unused_wdata;

    logic [N_GPIO-1:0] data_out;
    logic [N_GPIO-1:0] dir;
    logic [N_GPIO-1:0] rise_en;
    logic [N_GPIO-1:0] fall_en;
    logic [N_GPIO-1:0] irq_status;
    logic [N_GPIO-1:0] s1, s2, s3;
    logic [N_GPIO-1:0] evt;
    logic [N_GPIO-1:0] w1c_mask;
    logic [31:0]       rd_word;

    // Zero-extended address so the out-of-range test works for any ADDR_W.
    assign addr_ext     = 32'(PADDR);
    assign reg_idx      = addr_ext[4:2];
    assign addr_err     = (addr_ext[1:0] != 2'b00) || (addr_ext >= 32'h20);
    assign wdata_n      = PWDATA[N_GPIO-1:0];
    assign unused_wdata = PWDATA;

    assign ready   = (state == ST_ACCESS) && PSEL && PENABLE && (wait_cnt == WS);
    assign wr_en   = ready && PWRITE && !addr_err;

    assign PREADY  = ready;
    assign PSLVERR = ready && addr_err;
    assign PRDATA  = (ready && !PWRITE && !addr_err) ? rd_word : 32'h0;

    assign gpio_out  = data_out;
    assign gpio_oe   = dir;
    assign irq       = |irq_status;
    assign dbg_state = state;

    // Edge detect compares the synchronised value with its one-cycle history.
    assign evt      = (s2 & ~s3 & rise_en) | (~s2 & s3 & fall_en);
    assign w1c_mask = (wr_en && reg_idx == REG_IRQ_STAT) ? wdata_n : '0;

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_DATA_OUT: rd_word[N_GPIO-1:0] = data_out;
            REG_DIR:      rd_word[N_GPIO-1:0] = dir;
            REG_DATA_IN:  rd_word[N_GPIO-1:0] = s2;
            REG_RISE_EN:  rd_word[N_GPIO-1:0] = rise_en;
            REG_FALL_EN:  rd_word[N_GPIO-1:0] = fall_en;
            REG_IRQ_STAT: rd_word[N_GPIO-1:0] = irq_status;
            default:      rd_word = '0;
        endcase
    end

    // Transfer FSM and wait-state counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= 4'd0;
                    if (PSEL && !PENABLE) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL || ready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Register file, input synchroniser and interrupt status.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out   <= '0;
            dir        <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            irq_status <= '0;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= s2;
            // A new event wins over a simultaneous write-1-to-clear.
            irq_status <= (irq_status & ~w1c_mask) | evt;
            if (wr_en) begin
                case (reg_idx)
                    REG_DATA_OUT: data_out <= wdata_n;
                    REG_DIR:      dir      <= wdata_n;
                    REG_RISE_EN:  rise_en  <= wdata_n;
                    REG_FALL_EN:  fall_en  <= wdata_n;
                    REG_OUT_SET:  data_out <= data_out | wdata_n;
                    REG_OUT_CLR:  data_out <= data_out & ~wdata_n;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
module tb_apb_gpio_ctrl;

  localparam int N_GPIO = 16;
  localparam int ADDR_W = 8;
  localparam int WS     = 3;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic [N_GPIO-1:0] gpio_in, gpio_out, gpio_oe;
  logic              irq;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  apb_gpio_ctrl #(.N_GPIO(N_GPIO), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rd;
    logic              exp_err;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: one full APB transfer, samples the completion cycle at negedge
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits);
    logic done;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; done = 1'b0; rd = '0; err = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        done = 1'b1; rd = PRDATA; err = PSLVERR;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL pready_timeout: addr 0x%02h got no PREADY within 20 cycles", addr);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic xfer_chk(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(wr, addr, wd, rd, err, waits);
    check({name, " prdata"}, rd, exp_rd);
    check({name, " pslverr"}, {31'b0, err}, {31'b0, exp_err});
    check({name, " waits"}, waits, WS);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " pready"},   {31'b0, PREADY},  32'h0);
    check({name, " pslverr"},  {31'b0, PSLVERR}, 32'h0);
    check({name, " prdata"},   PRDATA,           32'h0);
    check({name, " gpio_out"}, 32'(gpio_out),    32'h0);
    check({name, " gpio_oe"},  32'(gpio_oe),     32'h0);
    check({name, " irq"},      {31'b0, irq},     32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    vecs[0]  = '{1'b1, 8'h04, 32'h0000_00FF, 32'h0, 1'b0}; // DIR
    vecs[1]  = '{1'b1, 8'h00, 32'h0000_00A5, 32'h0, 1'b0}; // DATA_OUT
    vecs[2]  = '{1'b1, 8'h18, 32'h0000_0100, 32'h0, 1'b0}; // OUT_SET
    vecs[3]  = '{1'b1, 8'h1C, 32'h0000_0001, 32'h0, 1'b0}; // OUT_CLR
    vecs[4]  = '{1'b0, 8'h00, 32'h0, 32'h0000_01A4, 1'b0};
    vecs[5]  = '{1'b0, 8'h04, 32'h0, 32'h0000_00FF, 1'b0};
    vecs[6]  = '{1'b0, 8'h18, 32'h0, 32'h0, 1'b0};         // OUT_SET reads 0
    vecs[7]  = '{1'b0, 8'h1C, 32'h0, 32'h0, 1'b0};         // OUT_CLR reads 0
    vecs[8]  = '{1'b0, 8'h08, 32'h0, 32'h0000_0005, 1'b0}; // DATA_IN
    vecs[9]  = '{1'b1, 8'h20, 32'h0000_FFFF, 32'h0, 1'b1}; // out of range
    vecs[10] = '{1'b1, 8'h02, 32'h0, 32'h0, 1'b1};         // misaligned
    vecs[11] = '{1'b1, 8'h24, 32'h0, 32'h0, 1'b1};         // aliases DIR if high bits ignored
    vecs[12] = '{1'b1, 8'h08, 32'h0000_1234, 32'h0, 1'b0}; // DATA_IN write ignored
    vecs[13] = '{1'b0, 8'h00, 32'h0, 32'h0000_01A4, 1'b0};
    vecs[14] = '{1'b0, 8'h04, 32'h0, 32'h0000_00FF, 1'b0};
    vecs[15] = '{1'b0, 8'h08, 32'h0, 32'h0000_0005, 1'b0};
    vecs[16] = '{1'b0, 8'h02, 32'h0, 32'h0, 1'b1};
    vecs[17] = '{1'b0, 8'h20, 32'h0, 32'h0, 1'b1};
    vecs[18] = '{1'b0, 8'h14, 32'h0, 32'h0, 1'b0};         // IRQ_STATUS idle
    vecs[19] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0, 1'b0}; // bits >= N_GPIO dropped
    vecs[20] = '{1'b0, 8'h04, 32'h0, 32'h0000_FFFF, 1'b0};
    vecs[21] = '{1'b1, 8'h04, 32'h0000_00FF, 32'h0, 1'b0};

    // reset block
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpio_in = '0;
    repeat (3) @(negedge PCLK);
    check_idle_outputs("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // reset in the middle of an ACCESS write: nothing commits
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hA5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer_chk(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, "midreset data_out");
    check("midreset gpio_out", 32'(gpio_out), 32'h0);

    gpio_in = 16'h0005;

    // table-driven register vectors
    for (int i = 0; i < NV; i++) begin
      xfer_chk(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
               $sformatf("vec%0d", i));
    end
    check("pins gpio_out", 32'(gpio_out), 32'h0000_01A4);
    check("pins gpio_oe",  32'(gpio_oe),  32'h0000_00FF);

    // PSEL dropped during wait states: write aborted
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hFFFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    xfer_chk(1'b0, 8'h00, 32'h0, 32'h0000_01A4, 1'b0, "abort data_out");

    // rising-edge interrupt on bit 0
    xfer_chk(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0, "rise_en wr");
    gpio_in = 16'h0004;
    repeat (4) @(posedge PCLK);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h0, 1'b0, "fall no_en");
    @(posedge PCLK); #1;
    gpio_in = 16'h0005;
    @(posedge PCLK); @(negedge PCLK);
    check("rise edge1 irq", {31'b0, irq}, 32'h0);
    @(posedge PCLK); @(negedge PCLK);
    check("rise edge2 irq", {31'b0, irq}, 32'h0);
    @(posedge PCLK); @(negedge PCLK);
    check("rise edge3 irq", {31'b0, irq}, 32'h1);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h1, 1'b0, "rise status");
    xfer_chk(1'b1, 8'h14, 32'h1, 32'h0, 1'b0, "rise w1c");
    check("rise w1c irq", {31'b0, irq}, 32'h0);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h0, 1'b0, "rise cleared");

    // W1C commit edge coincides with a new rising event on bit 0
    gpio_in = 16'h0004;
    repeat (4) @(posedge PCLK);
    fork
      apb_xfer(1'b1, 8'h14, 32'h1, rd, err, waits);
      begin
        repeat (3) @(posedge PCLK);
        #2;
        gpio_in = 16'h0005;
      end
    join
    check("collide irq", {31'b0, irq}, 32'h1);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h1, 1'b0, "collide status");
    xfer_chk(1'b1, 8'h14, 32'h1, 32'h0, 1'b0, "collide w1c");

    // falling-edge interrupt on bit 1; rising on bit 1 must not set
    xfer_chk(1'b1, 8'h10, 32'h2, 32'h0, 1'b0, "fall_en wr");
    gpio_in = 16'h0007;
    repeat (4) @(posedge PCLK);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h0, 1'b0, "bit1 rise no_set");
    gpio_in = 16'h0005;
    repeat (4) @(posedge PCLK);
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h2, 1'b0, "fall status");
    check("fall irq", {31'b0, irq}, 32'h1);
    xfer_chk(1'b1, 8'h10, 32'h0, 32'h0, 1'b0, "fall_en clr");
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h2, 1'b0, "status kept");
    xfer_chk(1'b1, 8'h14, 32'h2, 32'h0, 1'b0, "fall w1c");
    xfer_chk(1'b0, 8'h14, 32'h0, 32'h0, 1'b0, "fall cleared");
    check("final irq", {31'b0, irq}, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
